// File: rtl/morse_tx_controller_if.sv
// Letter request / Morse output bundle between the board I/O and the sequencer.
// Latency: none, wires only.
// Backpressure: none in the bundle; a full queue is signalled by QueueFull and Dropped.
interface morse_tx_controller_if;
    logic       Start;
    logic [2:0] Letter;
    logic       Abort;
    logic       DotDashOut;
    logic       NewBitOut;
    logic       Busy;
    logic       QueueFull;
    logic       QueueEmpty;
    logic       Dropped;

    modport master (
        output Start, Letter, Abort,
        input  DotDashOut, NewBitOut, Busy, QueueFull, QueueEmpty, Dropped
    );

    modport slave (
        input  Start, Letter, Abort,
        output DotDashOut, NewBitOut, Busy, QueueFull, QueueEmpty, Dropped
    );
endinterface

// File: rtl/morse_tx_controller.sv
// Morse sequencer: queues letters A..H and shifts each 12-bit dot/dash pattern out MSB-first.
// Latency: a letter pushed at edge N drives DotDashOut after edge N+1 when idle; each bit lasts TICKS_PER_SYMBOL cycles.
// Backpressure: none upstream; a Start into a full queue without a same-cycle pop is discarded and pulses Dropped.
module morse_tx_controller #(
    parameter int unsigned CLOCK_FREQUENCY  = 50000000,
    parameter int unsigned TICKS_PER_SYMBOL = CLOCK_FREQUENCY / 2,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned GAP_SYMBOLS      = 3
) (
    input  logic                  ClockIn,
    input  logic                  Reset,
    morse_tx_controller_if.slave  bus
);

    // Gap length is computed in 64 bits so large symbol rates cannot wrap.
    localparam logic [63:0] GAP_TICKS = 64'(GAP_SYMBOLS) * 64'(TICKS_PER_SYMBOL);
    localparam int unsigned TW = (TICKS_PER_SYMBOL > 1) ? $clog2(TICKS_PER_SYMBOL) : 1;
    localparam int unsigned GW = (GAP_TICKS > 64'd1) ? $clog2(GAP_TICKS) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICKS_PER_SYMBOL - 1);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(GAP_TICKS - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Dot/dash pattern, MSB transmitted first.
    function automatic logic [11:0] pattern_of(input logic [2:0] code);
        case (code)
            3'd0:    return 12'b1011_1000_0000;
            3'd1:    return 12'b1110_1010_1000;
            3'd2:    return 12'b1110_1011_1010;
            3'd3:    return 12'b1110_1010_0000;
            3'd4:    return 12'b1000_0000_0000;
            3'd5:    return 12'b1010_1110_1000;
            3'd6:    return 12'b1110_1110_1000;
            default: return 12'b1010_1010_0000;
        endcase
    endfunction

    // Number of shifts after the first bit (pattern length minus one).
    function automatic logic [3:0] last_bit_of(input logic [2:0] code);
        case (code)
            3'd0:    return 4'd4;
            3'd1:    return 4'd8;
            3'd2:    return 4'd10;
            3'd3:    return 4'd6;
            3'd4:    return 4'd0;
            3'd5:    return 4'd8;
            3'd6:    return 4'd8;
            default: return 4'd6;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [3:0]      bit_q, bit_d;
    logic [11:0]     sr_q, sr_d;
    logic            dot_q, dot_d;
    logic            newbit_q, newbit_d;
    logic            drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      mem_q [FIFO_DEPTH];

    logic            q_full, q_empty;
    logic            load, pop, push;
    logic [2:0]      head;
    logic [11:0]     head_pat;

    assign q_full   = (count_q == CW'(FIFO_DEPTH));
    assign q_empty  = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign head_pat = pattern_of(head);

    // Next-state: FSM, symbol/gap timing, shift register and queue bookkeeping.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        gap_d    = gap_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        dot_d    = dot_q;
        newbit_d = 1'b0;
        drop_d   = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        load     = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;

        if (bus.Abort) begin
            // Flush wins over everything, including a Start in the same cycle.
            state_d  = S_IDLE;
            tick_d   = '0;
            gap_d    = '0;
            bit_d    = '0;
            sr_d     = '0;
            dot_d    = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dot_d = 1'b0;
                    load  = !q_empty;
                end
                S_SEND: begin
                    if (tick_q == '0) begin
                        if (bit_q != '0) begin
                            sr_d     = sr_q << 1;
                            dot_d    = sr_q[10];
                            newbit_d = 1'b1;
                            bit_d    = bit_q - 4'd1;
                            tick_d   = TICK_RELOAD;
                        end else begin
                            dot_d   = 1'b0;
                            gap_d   = GAP_RELOAD;
                            state_d = S_GAP;
                        end
                    end else begin
                        tick_d = tick_q - TW'(1);
                    end
                end
                S_GAP: begin
                    dot_d = 1'b0;
                    if (gap_q == '0) begin
                        // Back-to-back letters skip IDLE entirely.
                        if (!q_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    dot_d   = 1'b0;
                end
            endcase

            if (load) begin
                pop      = 1'b1;
                sr_d     = head_pat;
                bit_d    = last_bit_of(head);
                tick_d   = TICK_RELOAD;
                dot_d    = head_pat[11];
                newbit_d = 1'b1;
                state_d  = S_SEND;
            end

            // A pop in the same cycle frees the slot, so a full queue can still accept.
            push   = bus.Start && (!q_full || pop);
            drop_d = bus.Start && !push;

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            gap_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            dot_q    <= 1'b0;
            newbit_q <= 1'b0;
            drop_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            gap_q    <= gap_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            dot_q    <= dot_d;
            newbit_q <= newbit_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Letter storage; contents are don't-care while the count says empty.
    always_ff @(posedge ClockIn) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.Letter;
        end
    end

    assign bus.DotDashOut = dot_q;
    assign bus.NewBitOut  = newbit_q;
    assign bus.Dropped    = drop_q;
    assign bus.Busy       = (state_q != S_IDLE) || !q_empty;
    assign bus.QueueFull  = q_full;
    assign bus.QueueEmpty = q_empty;

endmodule

// File: tb/tb_morse_tx_controller.sv
// Bench for morse_tx_controller: directed scenarios followed by random traffic.
// Expected outputs come from a letter-timeline model (start edge + pattern arithmetic).
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_morse_tx_controller;

    localparam int T = 4;
    localparam int G = 3;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;

    morse_tx_controller_if bus ();

    morse_tx_controller #(
        .CLOCK_FREQUENCY  (8),
        .TICKS_PER_SYMBOL (T),
        .FIFO_DEPTH       (D),
        .GAP_SYMBOLS      (G)
    ) dut (
        .ClockIn (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Timeline model: a letter occupies L*T symbol cycles plus G*T gap cycles from its start edge.
    int q[$];
    bit m_active = 1'b0;
    int m_letter = 0;
    int m_start  = 0;
    int m_edge   = 0;
    bit m_drop   = 1'b0;

    int hi_cnt   = 0;
    int nb_cnt   = 0;
    int drop_cnt = 0;

    function automatic logic [11:0] pat(input int c);
        case (c)
            0:       return 12'b101110000000;
            1:       return 12'b111010101000;
            2:       return 12'b111010111010;
            3:       return 12'b111010100000;
            4:       return 12'b100000000000;
            5:       return 12'b101011101000;
            6:       return 12'b111011101000;
            default: return 12'b101010100000;
        endcase
    endfunction

    // Length = position of the last 1 counted from the MSB, plus one.
    function automatic int plen(input int c);
        logic [11:0] p;
        int n;
        p = pat(c);
        n = 0;
        for (int i = 11; i >= 0; i--) begin
            if (p[i]) n = 12 - i;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit s, input int l, input bit a);
        m_edge++;
        m_drop = 1'b0;
        if (a) begin
            q.delete();
            m_active = 1'b0;
        end else begin
            if (m_active && m_edge == m_start + (plen(m_letter) + G) * T) m_active = 1'b0;
            if (!m_active && q.size() > 0) begin
                m_letter = q.pop_front();
                m_start  = m_edge;
                m_active = 1'b1;
            end
            if (s) begin
                if (q.size() < D) q.push_back(l);
                else m_drop = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 1'b0;
        m_drop   = 1'b0;
    endtask

    task automatic check_all();
        int k;
        logic [11:0] p;
        logic ed;
        logic en;
        ed = 1'b0;
        en = 1'b0;
        if (m_active) begin
            k = m_edge - m_start;
            p = pat(m_letter);
            if (k < plen(m_letter) * T) begin
                ed = p[11 - k / T];
                en = (k % T == 0);
            end
        end
        chk("dot", 32'(bus.DotDashOut), 32'(ed));
        chk("newbit", 32'(bus.NewBitOut), 32'(en));
        chk("busy", 32'(bus.Busy), 32'(m_active || q.size() > 0));
        chk("full", 32'(bus.QueueFull), 32'(q.size() == D));
        chk("empty", 32'(bus.QueueEmpty), 32'(q.size() == 0));
        chk("dropped", 32'(bus.Dropped), 32'(m_drop));
        if (bus.DotDashOut === 1'b1) hi_cnt++;
        if (bus.NewBitOut === 1'b1) nb_cnt++;
        if (bus.Dropped === 1'b1) drop_cnt++;
    endtask

    task automatic step(input bit s, input int l, input bit a);
        bus.Start  = s;
        bus.Letter = 3'(l);
        bus.Abort  = a;
        @(posedge clk);
        model_edge(s, l, a);
        @(negedge clk);
        check_all();
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0);
    endtask

    task automatic clear_counts();
        hi_cnt   = 0;
        nb_cnt   = 0;
        drop_cnt = 0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.Start  = 1'b0;
        bus.Letter = 3'd0;
        bus.Abort  = 1'b0;
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single E: one symbol high, then the 12-cycle gap.
        clear_counts();
        step(1'b1, 4, 1'b0);
        idle(30);
        chk("t1_dot_cycles", 32'(hi_cnt), 32'd4);
        chk("t1_newbit_pulses", 32'(nb_cnt), 32'd1);

        // Single A: 1,0,1,1,1 per slot.
        clear_counts();
        step(1'b1, 0, 1'b0);
        idle(40);
        chk("t2_dot_cycles", 32'(hi_cnt), 32'd16);
        chk("t2_newbit_pulses", 32'(nb_cnt), 32'd5);

        // H in flight, then C,A,B,D,E,F: queue fills, E and F dropped.
        clear_counts();
        step(1'b1, 7, 1'b0);
        step(1'b1, 2, 1'b0);
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        step(1'b1, 3, 1'b0);
        step(1'b1, 4, 1'b0);
        step(1'b1, 5, 1'b0);
        idle(240);
        chk("t3_dropped_pulses", 32'(drop_cnt), 32'd2);
        chk("t3_newbit_pulses", 32'(nb_cnt), 32'd39);
        chk("t3_dot_cycles", 32'(hi_cnt), 32'd108);

        // Abort in the third slot of B with two letters queued.
        step(1'b1, 1, 1'b0);
        step(1'b1, 0, 1'b0);
        step(1'b1, 4, 1'b0);
        idle(7);
        step(1'b1, 6, 1'b1);
        chk("t4_abort_dot", 32'(bus.DotDashOut), 32'd0);
        chk("t4_abort_empty", 32'(bus.QueueEmpty), 32'd1);
        chk("t4_abort_busy", 32'(bus.Busy), 32'd0);
        chk("t4_abort_nodrop", 32'(bus.Dropped), 32'd0);
        clear_counts();
        step(1'b1, 7, 1'b0);
        idle(50);
        chk("t4_h_newbit_pulses", 32'(nb_cnt), 32'd7);
        chk("t4_h_dot_cycles", 32'(hi_cnt), 32'd16);

        // Asynchronous reset between edges while D is being sent.
        step(1'b1, 3, 1'b0);
        step(1'b1, 0, 1'b0);
        idle(6);
        #2 rst = 1'b1;
        #1;
        chk("t5_areset_dot", 32'(bus.DotDashOut), 32'd0);
        chk("t5_areset_newbit", 32'(bus.NewBitOut), 32'd0);
        chk("t5_areset_busy", 32'(bus.Busy), 32'd0);
        chk("t5_areset_empty", 32'(bus.QueueEmpty), 32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        clear_counts();
        idle(10);
        chk("t5_residual_dot", 32'(hi_cnt), 32'd0);
        chk("t5_residual_newbit", 32'(nb_cnt), 32'd0);

        // Full queue, gap expiring while Start is high: pop and push together.
        repeat (5) step(1'b1, 4, 1'b0);
        idle(12);
        chk("t6_full_before", 32'(bus.QueueFull), 32'd1);
        step(1'b1, 6, 1'b0);
        chk("t6_full_after", 32'(bus.QueueFull), 32'd1);
        chk("t6_no_drop", 32'(bus.Dropped), 32'd0);
        chk("t6_newbit", 32'(bus.NewBitOut), 32'd1);
        idle(130);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(3) == 0), int'($urandom_range(7)), ($urandom_range(199) == 0));
        end
        idle(300);
        chk("final_busy", 32'(bus.Busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
